// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the word-addressed RAM: one load/store at a time,
// issued as a setup / strobe / release sequence with a registered load result.
module mem_access_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     req_ready,
    output logic                     resp_done,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_access_ctrl: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       op_write;

    // The address/data registers feed the RAM pins directly, so they stay
    // stable for the whole transaction and keep their last value in IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            op_write    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            resp_rdata  <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_address <= req_addr;
                        mem_wdata   <= req_wdata;
                        op_write    <= req_write;
                    end
                end
                SETUP: begin
                    wait_cnt <= WAIT_LOAD;
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (!op_write) begin
                            resp_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes and handshakes are decoded from state alone, so nothing on the
    // request side can reach the RAM pins combinationally.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_done  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                mem_read  = ~op_write;
                mem_write = op_write;
                if (wait_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three controllers (WAIT_CYCLES 1, 4, 3), each on its own
// behavioural RAM, checked against a transaction-level schedule and memory model.
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr;
    logic          req_valid   [3];
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready   [3];
    logic          resp_done   [3];
    logic [DW-1:0] resp_rdata  [3];
    logic          mem_read    [3];
    logic          mem_write   [3];
    logic [AW-1:0] mem_address [3];
    logic [DW-1:0] mem_wdata   [3];
    logic [DW-1:0] mem_rdata   [3];

    logic [DW-1:0] ram       [3][512];
    logic [DW-1:0] ref_mem   [3][512];
    logic [DW-1:0] ref_rdata [3];

    logic          fill_en;
    logic          pl_en;
    int            pl_d;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic          tr_rd    [32];
    logic          tr_wr    [32];
    logic          tr_done  [32];
    logic          tr_ready [32];
    logic [AW-1:0] tr_addr  [32];
    logic [DW-1:0] tr_wd    [32];
    logic [DW-1:0] tr_rdata [32];

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] fill_word(int g, int i);
        return DW'(32'hA5A5_0000 ^ (g << 20) ^ (i * 40503));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_ctrl #(
            .DATA_WIDTH   (DW),
            .ADDRESS_WIDTH(AW),
            .WAIT_CYCLES  (g == 0 ? 1 : (g == 1 ? 4 : 3))
        ) dut (
            .clk        (clk),
            .clr        (clr),
            .req_valid  (req_valid[g]),
            .req_write  (req_write),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_ready  (req_ready[g]),
            .resp_done  (resp_done[g]),
            .resp_rdata (resp_rdata[g]),
            .mem_read   (mem_read[g]),
            .mem_write  (mem_write[g]),
            .mem_address(mem_address[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
        assign mem_rdata[g] = ram[g][mem_address[g]];
    end

    // Behavioural RAMs: asynchronous read, write on the clock edge while the strobe is high.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (fill_en) begin
                for (int i = 0; i < 512; i++) ram[g][i] <= fill_word(g, i);
            end else if (pl_en && pl_d == g) begin
                ram[g][pl_addr] <= pl_data;
            end else if (mem_write[g]) begin
                ram[g][mem_address[g]] <= mem_wdata[g];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en   = 1'b1;
        pl_d    = d;
        pl_addr = a;
        pl_data = v;
        tick();
        pl_en = 1'b0;
        ref_mem[d][a] = v;
    endtask

    // Drives one request into an idle controller and records its outputs for
    // the cycles after acceptance (index k = cycles after the accepting edge).
    task automatic issue(input int d, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int w);
        req_valid[d] = 1'b1;
        req_write    = wr;
        req_addr     = a;
        req_wdata    = wd;
        if (wr) ref_mem[d][a] = wd;
        else    ref_rdata[d]  = ref_mem[d][a];
        for (int k = 1; k <= w + 3; k++) begin
            tick();
            if (k == 1) begin
                req_valid[d] = 1'b0;
                req_write    = ~wr;
                req_addr     = AW'($urandom);
                req_wdata    = $urandom;
            end
            tr_rd[k]    = mem_read[d];
            tr_wr[k]    = mem_write[d];
            tr_done[k]  = resp_done[d];
            tr_ready[k] = req_ready[d];
            tr_addr[k]  = mem_address[d];
            tr_wd[k]    = mem_wdata[d];
            tr_rdata[k] = resp_rdata[d];
        end
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        fill_en   = 1'b1;
        req_write = 1'b1;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        for (int g = 0; g < 3; g++) req_valid[g] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            fill_en = 1'b0;
            for (int g = 0; g < 3; g++) begin
                vectors++;
                if ({mem_read[g], mem_write[g], resp_done[g], req_ready[g]} !== 4'b0001) begin
                    miscompares++;
                    $display("[TB] FAIL reset_ctrl dut%0d: got rd/wr/done/ready=%b, want 0001", g,
                             {mem_read[g], mem_write[g], resp_done[g], req_ready[g]});
                end
                vectors++;
                if (mem_address[g] !== '0 || mem_wdata[g] !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_bus dut%0d: got addr=%h wdata=%h, want 0/0", g,
                             mem_address[g], mem_wdata[g]);
                end
                vectors++;
                if (resp_rdata[g] !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_rdata dut%0d: got %h, want 0", g, resp_rdata[g]);
                end
            end
        end
        clr = 1'b0;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0;
            ref_rdata[g] = '0;
        end
    endtask

    task automatic test_store_load();
        logic [3:0] exp;
        issue(0, 1'b1, 9'h005, 32'hDEAD_BEEF, 1);
        for (int k = 1; k <= 4; k++) begin
            exp = {1'b0, k == 2, k == 3, k == 4};
            vectors++;
            if ({tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]} !== exp) begin
                miscompares++;
                $display("[TB] FAIL store_seq k=%0d: got %b, want %b", k,
                         {tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]}, exp);
            end
            vectors++;
            if (tr_addr[k] !== 9'h005 || tr_wd[k] !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("[TB] FAIL store_bus k=%0d: got %h/%h, want 005/deadbeef", k, tr_addr[k], tr_wd[k]);
            end
        end
        issue(0, 1'b0, 9'h005, 32'h0, 1);
        for (int k = 1; k <= 4; k++) begin
            exp = {k == 2, 1'b0, k == 3, k == 4};
            vectors++;
            if ({tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]} !== exp || tr_addr[k] !== 9'h005) begin
                miscompares++;
                $display("[TB] FAIL load_seq k=%0d: got %b addr %h, want %b addr 005", k,
                         {tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]}, tr_addr[k], exp);
            end
        end
        vectors++;
        if (tr_rdata[3] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL load_rdata: got %h, want deadbeef", tr_rdata[3]);
        end
    endtask

    task automatic test_strobe_timing();
        logic [3:0]    exp;
        logic [DW-1:0] want;
        want = ref_mem[1][9'h1FF];
        issue(1, 1'b0, 9'h1FF, $urandom, 4);
        for (int k = 1; k <= 7; k++) begin
            exp = {k >= 2 && k <= 5, 1'b0, k == 6, k == 7};
            vectors++;
            if ({tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]} !== exp || tr_addr[k] !== 9'h1FF) begin
                miscompares++;
                $display("[TB] FAIL strobe4 k=%0d: got %b addr %h, want %b addr 1ff", k,
                         {tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]}, tr_addr[k], exp);
            end
        end
        vectors++;
        if (tr_rdata[6] !== want) begin
            miscompares++;
            $display("[TB] FAIL strobe4_rdata: got %h, want %h", tr_rdata[6], want);
        end
    endtask

    task automatic test_store_no_disturb();
        logic [3:0] exp;
        preload(2, 9'h000, 32'h0000_0001);
        issue(2, 1'b0, 9'h000, $urandom, 3);
        vectors++;
        if (tr_rdata[5] !== 32'h0000_0001 || tr_done[5] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nodist_load: got rdata %h done %b, want 00000001 1", tr_rdata[5], tr_done[5]);
        end
        issue(2, 1'b1, 9'h010, 32'h1234_5678, 3);
        for (int k = 1; k <= 6; k++) begin
            exp = {1'b0, k >= 2 && k <= 4, k == 5, k == 6};
            vectors++;
            if ({tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]} !== exp || tr_rdata[k] !== 32'h0000_0001) begin
                miscompares++;
                $display("[TB] FAIL nodist_store k=%0d: got %b rdata %h, want %b rdata 00000001", k,
                         {tr_rd[k], tr_wr[k], tr_done[k], tr_ready[k]}, tr_rdata[k], exp);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        req_valid[2] = 1'b1;
        req_write    = 1'b0;
        req_addr     = 9'h0AB;
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        vectors++;
        if (mem_read[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre: got mem_read %b, want 1", mem_read[2]);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int g = 0; g < 3; g++) ref_rdata[g] = '0;
        vectors++;
        if ({mem_read[2], mem_write[2], resp_done[2], req_ready[2]} !== 4'b0001 || resp_rdata[2] !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_after: got %b rdata %h, want 0001 rdata 0",
                     {mem_read[2], mem_write[2], resp_done[2], req_ready[2]}, resp_rdata[2]);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (resp_done[2] !== 1'b0 || mem_read[2] !== 1'b0 || resp_rdata[2] !== '0) begin
                miscompares++;
                $display("[TB] FAIL midrst_quiet c=%0d: got done %b rd %b rdata %h, want 0 0 0", c,
                         resp_done[2], mem_read[2], resp_rdata[2]);
            end
        end
    endtask

    // req_valid held high with random fields changing every cycle; requests are
    // expected exactly every w+3 edges, using whatever was on the inputs then.
    task automatic test_back_to_back(input int d, input int w, input int n_edges);
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_data;
        bit            acc_wr;
        int            p;
        logic [3:0]    exp;
        acc_addr = '0;
        acc_data = '0;
        acc_wr   = 1'b0;
        req_valid[d] = 1'b1;
        req_write    = 1'($urandom);
        req_addr     = AW'($urandom);
        req_wdata    = $urandom;
        for (int e = 1; e <= n_edges; e++) begin
            if ((e - 1) % (w + 3) == 0) begin
                acc_addr = req_addr;
                acc_data = req_wdata;
                acc_wr   = req_write;
                if (acc_wr) ref_mem[d][acc_addr] = acc_data;
                else        ref_rdata[d] = ref_mem[d][acc_addr];
            end
            tick();
            p   = e % (w + 3);
            exp = {!acc_wr && p >= 2 && p <= w + 1, acc_wr && p >= 2 && p <= w + 1, p == w + 2, p == 0};
            vectors++;
            if ({mem_read[d], mem_write[d], resp_done[d], req_ready[d]} !== exp) begin
                miscompares++;
                $display("[TB] FAIL b2b_ctrl dut%0d e=%0d: got %b, want %b", d, e,
                         {mem_read[d], mem_write[d], resp_done[d], req_ready[d]}, exp);
            end
            vectors++;
            if (mem_address[d] !== acc_addr || mem_wdata[d] !== acc_data) begin
                miscompares++;
                $display("[TB] FAIL b2b_bus dut%0d e=%0d: got %h/%h, want %h/%h", d, e,
                         mem_address[d], mem_wdata[d], acc_addr, acc_data);
            end
            if (p == w + 2 || p == 0) begin
                vectors++;
                if (resp_rdata[d] !== ref_rdata[d]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_rdata dut%0d e=%0d: got %h, want %h", d, e,
                             resp_rdata[d], ref_rdata[d]);
                end
            end
            req_write = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       req_addr = '0;
                1:       req_addr = '1;
                default: req_addr = AW'($urandom);
            endcase
            req_wdata = $urandom;
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        clr       = 1'b0;
        fill_en   = 1'b0;
        pl_en     = 1'b0;
        pl_d      = 0;
        pl_addr   = '0;
        pl_data   = '0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0;
            ref_rdata[g] = '0;
            for (int i = 0; i < 512; i++) ref_mem[g][i] = fill_word(g, i);
        end
        test_reset();
        test_store_load();
        test_strobe_timing();
        test_store_no_disturb();
        test_reset_mid_access();
        test_back_to_back(0, 1, 60);
        test_back_to_back(1, 4, 63);
        test_back_to_back(2, 3, 60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
